// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register file dump reader.
//   state_e : dump sequencer states
//   beat_t  : one output beat (even index plus the two register values), default widths
//   Def*    : default sizes matching the core's register file
package regfile_dump_reader_pkg;

  localparam int unsigned DefN     = 32;
  localparam int unsigned DefNregs = 32;
  localparam int unsigned DefAw    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold,
    StDone
  } state_e;

  typedef struct packed {
    logic [DefAw-1:0] idx;
    logic [DefN-1:0]  data1;
    logic [DefN-1:0]  data2;
  } beat_t;

endpackage

// File: rtl/regdump_beat_reg.sv
// Single-entry holding register with a valid/ready output side.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : capture load_beat and raise valid
//   load_beat : beat to capture
//   ready     : downstream accepts; valid drops after a handshake
//   valid     : beat held and offered
//   beat      : held beat, stable while valid is high and not accepted
module regdump_beat_reg #(
  parameter type beat_t = regfile_dump_reader_pkg::beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  beat_t load_beat,
  input  logic  ready,
  output logic  valid,
  output beat_t beat
);

  logic  valid_q;
  beat_t beat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      beat_q  <= load_beat;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign beat  = beat_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side dump sequencer for the register file. On start it walks register pairs
// (2k, 2k+1) through the two read ports and streams (idx, data1, data2) beats.
//   clk, rst               : clock, asynchronous active-low reset
//   start                  : begin a dump (sampled only when idle)
//   busy, done             : dump in progress / one-cycle completion pulse
//   readreg1, readreg2     : registered read-port addresses (even / odd)
//   read_data1, read_data2 : combinational read-port data
//   out_valid, out_ready   : beat handshake
//   out_idx, out_data1/2   : beat contents
//   checksum               : XOR of all beat data words (only with REGDUMP_CHECKSUM_EN)
// Optional feature macro: REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned n     = DefN,
  parameter int unsigned NREGS = DefNregs,
  parameter int unsigned AW    = DefAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] readreg1,
  output logic [AW-1:0] readreg2,
  input  logic [n-1:0]  read_data1,
  input  logic [n-1:0]  read_data2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [n-1:0]  out_data1,
  output logic [n-1:0]  out_data2
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [n-1:0]  checksum
`endif
);

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [n-1:0]  data1;
    logic [n-1:0]  data2;
  } dump_beat_t;

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] rr1_q, rr1_d, rr2_q;
  logic          load;
  logic          handshake;
  logic          last_pair;
  dump_beat_t    load_beat, beat;

  assign handshake = out_valid && out_ready;
  assign last_pair = (k_q == AW'(NREGS / 2 - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          k_d     = '0;
        end
      end
      StIssue: begin
        load    = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (handshake) begin
          if (last_pair) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Addresses are registered so they only move on edges; they hold through HOLD
  // so the read ports keep pointing at the beat being offered.
  always_comb begin
    rr1_d = '0;
    if (state_d == StIssue) begin
      rr1_d = {k_d[AW-2:0], 1'b0};
    end else if (state_d == StHold) begin
      rr1_d = rr1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      rr1_q   <= '0;
      rr2_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rr1_q   <= rr1_d;
      rr2_q   <= (state_d == StIdle || state_d == StDone) ? '0 : {rr1_d[AW-1:1], 1'b1};
    end
  end

  assign load_beat = '{idx: rr1_q, data1: read_data1, data2: read_data2};

  regdump_beat_reg #(
    .beat_t(dump_beat_t)
  ) u_beat_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_beat(load_beat),
    .ready    (out_ready),
    .valid    (out_valid),
    .beat     (beat)
  );

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign readreg1  = rr1_q;
  assign readreg2  = rr2_q;
  assign out_idx   = beat.idx;
  assign out_data1 = beat.data1;
  assign out_data2 = beat.data2;

`ifdef REGDUMP_CHECKSUM_EN
  logic [n-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (state_q == StIdle && start) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q ^ beat.data1 ^ beat.data2;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

  localparam int N     = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NBEAT = NREGS / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] readreg1, readreg2;
  logic [N-1:0]  read_data1, read_data2;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_idx;
  logic [N-1:0]  out_data1, out_data2;
`ifdef REGDUMP_CHECKSUM_EN
  logic [N-1:0]  checksum;
`endif

  logic [N-1:0] regs [NREGS];
  assign read_data1 = regs[readreg1];
  assign read_data2 = regs[readreg2];

  regfile_dump_reader #(.n(N), .NREGS(NREGS), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .readreg1  (readreg1),
    .readreg2  (readreg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data1 (out_data1),
    .out_data2 (out_data2)
`ifdef REGDUMP_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a sequence of NBEAT beats (2b, regs[2b], regs[2b+1]).
  // A beat is offered two cycles after acceptance or after the previous handshake,
  // and done follows the cycle of the last handshake.
  bit           m_active = 0;
  bit           m_done_due = 0;
  int           m_vwait = 0;
  int           beat_cnt = 0;
  int           done_cnt = 0;
  int           busy_cnt = 0;
  logic [N-1:0] m_cks = '0;
  int           start_cyc = 0, first_valid_cyc = -1, done_cyc = 0;
  int           hs_cyc [NBEAT];
  logic [N-1:0] lit_d1_4 = '1, lit_d2_4 = '1, lit_d1_6 = '1, lit_cks = '1;

  always @(negedge clk) begin
    bit nxt_done;
    bit exp_valid;
    nxt_done = 0;
    if (!rst) begin
      m_active = 0; m_done_due = 0; m_vwait = 0; beat_cnt = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_rr1", readreg1, 0);
      chk("rst_rr2", readreg2, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_d1", out_data1, 0);
      chk("rst_d2", out_data2, 0);
    end else begin
      if (m_vwait > 0) m_vwait--;
      exp_valid = m_active && !m_done_due && m_vwait == 0;
      if (busy) busy_cnt++;
      chk("busy", busy, m_active);
      chk("done", done, m_done_due);
      chk("out_valid", out_valid, exp_valid);
      if (m_active && m_vwait == 1) begin
        chk("issue_rr1", readreg1, 64'(2 * beat_cnt));
        chk("issue_rr2", readreg2, 64'(2 * beat_cnt + 1));
      end
      if (m_done_due) begin
        done_cnt++;
        done_cyc = cyc;
        chk("beats_at_done", beat_cnt, NBEAT);
`ifdef REGDUMP_CHECKSUM_EN
        chk("checksum", checksum, m_cks);
        lit_cks = checksum;
`endif
      end
      if (out_valid && exp_valid) begin
        if (beat_cnt == 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
        chk("hold_rr1", readreg1, 64'(out_idx));
        chk("hold_rr2", readreg2, 64'(out_idx) + 1);
        chk("idx", out_idx, 64'(2 * beat_cnt));
        chk("data1", out_data1, regs[2 * beat_cnt]);
        chk("data2", out_data2, regs[2 * beat_cnt + 1]);
        if (out_ready) begin
          if (out_idx == 4) begin lit_d1_4 = out_data1; lit_d2_4 = out_data2; end
          if (out_idx == 6) lit_d1_6 = out_data1;
          m_cks ^= regs[2 * beat_cnt] ^ regs[2 * beat_cnt + 1];
          if (beat_cnt < NBEAT) hs_cyc[beat_cnt] = cyc;
          beat_cnt++;
          if (beat_cnt == NBEAT) nxt_done = 1;
          else m_vwait = 2;
        end
      end
      if (!m_active) begin
        chk("idle_rr1", readreg1, 0);
        chk("idle_rr2", readreg2, 0);
      end
      if (m_done_due) begin
        m_active = 0;
      end else if (start && !m_active) begin
        m_active = 1; m_vwait = 2; beat_cnt = 0; m_cks = '0;
        start_cyc = cyc; first_valid_cyc = -1; busy_cnt = 0;
      end
      m_done_due = nxt_done;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
  endtask

  // Runs one dump; optional stall, ignored restart, random start spam or mid-dump reset.
  task automatic run_dump(input bit rnd_ready, input int stall_idx, input int restart_idx,
                          input int abort_idx, input bit spam_start);
    int  d0 = done_cnt;
    int  guard = 0;
    bit  stalled = 0;
    start = 1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cycle();
    start = 0;
    while (done_cnt == d0 && guard < 2000) begin
      guard++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = spam_start ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (stall_idx >= 0 && !stalled && out_valid && int'(out_idx) == stall_idx) begin
        out_ready = 0;
        repeat (7) cycle();
        stalled = 1;
        out_ready = 1;
      end
      if (restart_idx >= 0 && out_valid && int'(out_idx) == restart_idx) start = 1;
      if (abort_idx >= 0 && out_valid && int'(out_idx) == abort_idx) begin
        out_ready = 0;
        #2;
        rst = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_rr1", readreg1, 0);
        chk("abort_rr2", readreg2, 0);
        chk("abort_done", done, 0);
        start = 0;
        repeat (2) cycle();
        rst = 1;
        repeat (4) cycle();
        chk("abort_no_done", done_cnt, d0);
        return;
      end
      cycle();
    end
    start = 0;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL dump_timeout: no done within %0d cycles", guard);
    end
  endtask

  initial begin
    int d0;
    rst = 0; start = 0; out_ready = 0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    repeat (3) cycle();
    rst = 1;
    repeat (2) cycle();

    // Directed dump with ready tied high: contents, timing, single done.
    regs[5] = 32'd20; regs[6] = 32'd100;
    d0 = done_cnt;
    run_dump(0, -1, -1, -1, 0);
    repeat (3) cycle();
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_idx4_d1", lit_d1_4, 0);
    chk("t1_idx4_d2", lit_d2_4, 20);
    chk("t1_idx6_d1", lit_d1_6, 100);
    chk("t1_first_valid", first_valid_cyc - start_cyc, 2);
    chk("t1_done_cyc", done_cyc - start_cyc, 33);
    chk("t1_done_after_hs", done_cyc - hs_cyc[NBEAT-1], 1);
    chk("t1_busy_cycles", busy_cnt, 33);
    for (int i = 1; i < NBEAT; i++) chk("t1_beat_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
`ifdef REGDUMP_CHECKSUM_EN
    chk("t1_checksum_lit", lit_cks, 112);
`endif

    // Stall at idx 2, ignored restart at idx 8, then an immediate fresh dump.
    randomize_regs();
    d0 = done_cnt;
    run_dump(0, 2, 8, -1, 0);
    run_dump(1, -1, -1, -1, 0);
    chk("t2_two_dumps", done_cnt - d0, 2);

    // Reset mid-HOLD at idx 10, then a full dump restarting from 0.
    randomize_regs();
    run_dump(1, -1, -1, 10, 0);
    d0 = done_cnt;
    run_dump(1, -1, -1, -1, 0);
    chk("t3_restart_dump", done_cnt - d0, 1);

    // Random contents, random back-pressure, start spam during dumps.
    for (int r = 0; r < 4; r++) begin
      randomize_regs();
      regs[0] = (r == 0) ? 32'hdead_beef : regs[0];
      run_dump(1, -1, -1, -1, 1);
      repeat ($urandom_range(0, 3)) cycle();
    end

    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
